// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller for the synchronous fifo block.
// Issues read_en toward the FIFO and captures data_out one cycle later.
// Words go into a 2-entry ordered skid buffer and are presented downstream
// on an out_valid/out_ready stream.
// With a non-stalling consumer the stream runs at one word per cycle. While
// the consumer stalls, no more than two words are ever outstanding (held
// plus in flight).
// Optional feature: define FIFO_RD_CNT_EN to add the rd_count output. It
// counts delivered words and wraps.
// read_en depends combinationally on out_ready and empty. This allows a read
// in the same cycle as a dequeue, which keeps the stream free of bubbles.

module fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  read_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  rd_count
`endif
);

    if (DATA_WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_param
        $error("fifo_rd_ctrl: DATA_WIDTH and CNT_WIDTH must be at least 1");
    end

    logic [1:0]            occ_q;
    logic [1:0]            occ_d;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;
    logic [DATA_WIDTH-1:0] head_d;
    logic [DATA_WIDTH-1:0] tail_d;
    logic                  deq;
    logic [1:0]            pending;
    logic [1:0]            occ_left;

    // Stream outputs, dequeue strobe and read issue decision.
    always_comb begin
        out_valid = ~rst & (occ_q != 2'd0);
        out_data  = out_valid ? head_q : '0;
        deq       = out_valid & out_ready;
        // Entries the buffer will hold next cycle, counting the capture now in flight.
        pending   = occ_q + {1'b0, inflight_q} - {1'b0, deq};
        occ_left  = occ_q - {1'b0, deq};
        read_en   = en & ~empty & ~rst & (pending < 2'd2);
        occ_d     = pending;
    end

    // Next buffer contents: shift on dequeue, then append the captured word behind what remains.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (deq) begin
            head_d = tail_q;
            tail_d = '0;
        end
        if (inflight_q) begin
            if (occ_left == 2'd0) begin
                head_d = data_out;
            end else begin
                tail_d = data_out;
            end
        end
    end

    // State registers; reset discards held and in-flight words.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= read_en;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

`ifdef FIFO_RD_CNT_EN
    // Delivered-word counter, wraps naturally at its width.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
        end else if (deq) begin
            rd_count <= rd_count + 1'b1;
        end
    end
`endif

endmodule
